// File: rtl/axis_maxpool_engine_pkg.sv
// Shared definitions for the 2x2 max-pool stage: tuser field layout, FSM states and beat classes.
package axis_maxpool_engine_pkg;

    localparam int unsigned OFS_IS_3X3         = 0;
    localparam int unsigned OFS_MAXPOOL_IS_MAX = 1;
    localparam int unsigned OFS_MAXPOOL_NOTMAX = 2;
    localparam int unsigned TUSER_FLAG_BITS    = 3;

    localparam int unsigned DEF_GROUPS  = 2;
    localparam int unsigned DEF_COPIES  = 2;
    localparam int unsigned DEF_MEMBERS = 2;

    localparam int unsigned BITS_CONV_CORE       = $clog2(DEF_GROUPS * DEF_COPIES * DEF_MEMBERS);
    localparam int unsigned I_IS_3X3             = BITS_CONV_CORE + OFS_IS_3X3;
    localparam int unsigned I_MAXPOOL_IS_MAX     = BITS_CONV_CORE + OFS_MAXPOOL_IS_MAX;
    localparam int unsigned I_MAXPOOL_IS_NOT_MAX = BITS_CONV_CORE + OFS_MAXPOOL_NOTMAX;
    localparam int unsigned TUSER_WIDTH_MAXPOOL  = BITS_CONV_CORE + TUSER_FLAG_BITS;

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    typedef enum logic [1:0] {
        BEAT_BYPASS,
        BEAT_FIRST,
        BEAT_SECOND
    } beat_t;

    function automatic beat_t classify(input logic not_max, input logic is_max);
        if (not_max)
            return BEAT_BYPASS;
        if (is_max)
            return BEAT_SECOND;
        return BEAT_FIRST;
    endfunction

endpackage

// File: rtl/maxpool_vmax_gu.sv
// Combinational signed max across COPIES for each of LANES words; copy c occupies lane block c.
module maxpool_vmax_gu
    import axis_maxpool_engine_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned LANES      = 16,
    parameter int unsigned COPIES     = 2
) (
    input  logic [COPIES*LANES*WORD_WIDTH-1:0] din,
    output logic [LANES*WORD_WIDTH-1:0]        dout
);

    always_comb begin
        dout = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            dout[l*WORD_WIDTH +: WORD_WIDTH] = din[l*WORD_WIDTH +: WORD_WIDTH];
            for (int unsigned c = 1; c < COPIES; c++) begin
                if ($signed(din[(c*LANES+l)*WORD_WIDTH +: WORD_WIDTH]) >
                    $signed(dout[l*WORD_WIDTH +: WORD_WIDTH]))
                    dout[l*WORD_WIDTH +: WORD_WIDTH] = din[(c*LANES+l)*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

endmodule

// File: rtl/axis_maxpool_engine.sv
// 2x2/stride-2 max-pool: vertical max across copies, horizontal max across beat pairs; not-max beats bypass.
module axis_maxpool_engine
    import axis_maxpool_engine_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned UNITS      = 8,
    parameter int unsigned GROUPS     = 2,
    parameter int unsigned COPIES     = 2,
    parameter int unsigned MEMBERS    = 2,
    localparam int unsigned BITS_CC   = $clog2(GROUPS * COPIES * MEMBERS),
    localparam int unsigned TUW       = BITS_CC + TUSER_FLAG_BITS,
    localparam int unsigned DW        = COPIES * GROUPS * UNITS * WORD_WIDTH
) (
    input  logic           aclk,
    input  logic           aresetn,
    input  logic           s_axis_tvalid,
    output logic           s_axis_tready,
    input  logic [DW-1:0]  s_axis_tdata,
    input  logic [TUW-1:0] s_axis_tuser,
    output logic           m_axis_tvalid,
    input  logic           m_axis_tready,
    output logic [DW-1:0]  m_axis_tdata,
    output logic [TUW-1:0] m_axis_tuser,
    output logic           m_err_pool
);

    localparam int unsigned LANES       = GROUPS * UNITS;
    localparam int unsigned LW          = LANES * WORD_WIDTH;
    localparam int unsigned IDX_IS_MAX  = BITS_CC + OFS_MAXPOOL_IS_MAX;
    localparam int unsigned IDX_NOT_MAX = BITS_CC + OFS_MAXPOOL_NOTMAX;

    state_t         state, state_n;
    beat_t          beat;
    logic [LW-1:0]  vmax, pmax, hold, hold_n;
    logic [TUW-1:0] hold_user, hold_user_n, out_user_n;
    logic [DW-1:0]  out_data_n;
    logic           out_load, err_n, out_free, flush, in_hs;

    maxpool_vmax_gu #(.WORD_WIDTH(WORD_WIDTH), .LANES(LANES), .COPIES(COPIES)) u_vmax (
        .din  (s_axis_tdata),
        .dout (vmax)
    );

    maxpool_vmax_gu #(.WORD_WIDTH(WORD_WIDTH), .LANES(LANES), .COPIES(2)) u_hmax (
        .din  ({vmax, hold}),
        .dout (pmax)
    );

    // A bypass beat arriving while a first beat is held is stalled one cycle so the hold drains first.
    assign out_free      = !m_axis_tvalid || m_axis_tready;
    assign flush         = (state == HOLD) && s_axis_tuser[IDX_NOT_MAX];
    assign s_axis_tready = out_free && !flush;
    assign in_hs         = s_axis_tvalid && s_axis_tready;
    assign beat          = classify(s_axis_tuser[IDX_NOT_MAX], s_axis_tuser[IDX_IS_MAX]);

    always_comb begin
        state_n     = state;
        hold_n      = hold;
        hold_user_n = hold_user;
        out_load    = 1'b0;
        out_data_n  = '0;
        out_user_n  = '0;
        err_n       = m_err_pool;
        case (state)
            IDLE: begin
                if (in_hs) begin
                    case (beat)
                        BEAT_BYPASS: begin
                            out_load   = 1'b1;
                            out_data_n = s_axis_tdata;
                            out_user_n = s_axis_tuser;
                        end
                        BEAT_FIRST: begin
                            hold_n      = vmax;
                            hold_user_n = s_axis_tuser;
                            state_n     = HOLD;
                        end
                        default: begin
                            out_load           = 1'b1;
                            out_data_n[LW-1:0] = vmax;
                            out_user_n         = s_axis_tuser;
                            err_n              = 1'b1;
                        end
                    endcase
                end
            end
            HOLD: begin
                if (flush && s_axis_tvalid && out_free) begin
                    out_load           = 1'b1;
                    out_data_n[LW-1:0] = hold;
                    out_user_n         = hold_user;
                    state_n            = IDLE;
                end else if (in_hs) begin
                    out_load = 1'b1;
                    if (beat == BEAT_SECOND) begin
                        out_data_n[LW-1:0] = pmax;
                        out_user_n         = s_axis_tuser;
                        state_n            = IDLE;
                    end else begin
                        out_data_n[LW-1:0] = hold;
                        out_user_n         = hold_user;
                        err_n              = 1'b1;
                        hold_n             = vmax;
                        hold_user_n        = s_axis_tuser;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= IDLE;
            hold          <= '0;
            hold_user     <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            m_err_pool    <= 1'b0;
        end else begin
            state      <= state_n;
            hold       <= hold_n;
            hold_user  <= hold_user_n;
            m_err_pool <= err_n;
            if (out_load) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= out_data_n;
                m_axis_tuser  <= out_user_n;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule
